// File: rtl/cmd_frame_tx_pkg.sv
// ------------------------------------------------------------------
// cmd_frame_tx_pkg : opcodes, frame headers, length tables, FSM state
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package cmd_frame_tx_pkg;

   typedef enum logic [1:0] {
      OP_RF_WR   = 2'b00,
      OP_RF_RD   = 2'b01,
      OP_ALU_OP  = 2'b10,
      OP_ALU_NOP = 2'b11
   } cmd_op_e;

   localparam logic [7:0] HDR_RF_WR   = 8'hAA;
   localparam logic [7:0] HDR_RF_RD   = 8'hBB;
   localparam logic [7:0] HDR_ALU_OP  = 8'hCC;
   localparam logic [7:0] HDR_ALU_NOP = 8'hDD;

   // Indexed by opcode: entry 0 is RF_WR, entry 3 is ALU_NOP.
   localparam logic [3:0][2:0] FRAME_LEN_TBL = {3'd2, 3'd4, 3'd2, 3'd3};
   localparam logic [3:0][1:0] RESP_LEN_TBL  = {2'd2, 2'd2, 2'd1, 2'd0};

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_OFFER     = 3'd1,
      S_WAIT_ACC  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_RESP      = 3'd4,
      S_FINISH    = 3'd5
   } state_e;

   function automatic logic [2:0] frame_len(input cmd_op_e op);
      return FRAME_LEN_TBL[op];
   endfunction

   function automatic logic [1:0] resp_len(input cmd_op_e op);
      return RESP_LEN_TBL[op];
   endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_frame_timer.sv
// ------------------------------------------------------------------
// cmd_frame_timer : loadable, saturating response-timeout down-counter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module cmd_frame_timer #(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   // Loading one less than the limit makes expiry land TIMEOUT_CYC cycles
   // after the busy level fell, counting the cycle the FSM samples it.
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= RELOAD;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/cmd_frame_tx.sv
// ------------------------------------------------------------------
// cmd_frame_tx : command framer over a byte UART with response capture
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module cmd_frame_tx
   import cmd_frame_tx_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int RF_ADDR     = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [RF_ADDR-1:0]      cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH-1:0]   cmd_a,
   input  logic [DATA_WIDTH-1:0]   cmd_b,
   input  logic [3:0]              cmd_fun,
   output logic [DATA_WIDTH-1:0]   tx_p_data,
   output logic                    tx_valid,
   input  logic                    tx_busy,
   input  logic [DATA_WIDTH-1:0]   rx_p_data,
   input  logic                    rx_valid,
   output logic [2*DATA_WIDTH-1:0] resp_data,
   output logic                    resp_valid,
   output logic                    timeout_err,
   output logic                    frame_busy
);

   state_e                state, state_nxt;
   cmd_op_e               op_q, op_in;
   logic [DATA_WIDTH-1:0] frame_q   [4];
   logic [DATA_WIDTH-1:0] frame_new [4];
   logic [1:0]            byte_idx;
   logic [1:0]            rx_cnt;
   logic [1:0]            last_idx;
   logic [1:0]            resp_last;
   logic [DATA_WIDTH-1:0] rx_lo;
   logic                  handshake;
   logic                  byte_done;
   logic                  last_byte;
   logic                  rx_take;
   logic                  rx_final;
   logic                  tmr_load;
   logic                  tmr_dec;
   logic                  tmr_expired;

   assign op_in     = cmd_op_e'(cmd_op);
   assign last_idx  = 2'(frame_len(op_q) - 3'd1);
   assign resp_last = resp_len(op_q) - 2'd1;
   assign handshake = (state == S_IDLE) && cmd_valid;
   assign byte_done = (state == S_WAIT_DONE) && !tx_busy;
   assign last_byte = (byte_idx == last_idx);
   assign rx_take   = (state == S_RESP) && rx_valid;
   assign rx_final  = rx_take && (rx_cnt == resp_last);
   assign tmr_load  = (byte_done && last_byte && (op_q != OP_RF_WR)) || rx_take;
   assign tmr_dec   = (state == S_RESP);

   assign cmd_ready  = (state == S_IDLE);
   assign frame_busy = (state != S_IDLE);

   // Frame image built from the live command fields; latched on handshake.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         frame_new[i] = '0;
      end
      unique case (op_in)
         OP_RF_WR: begin
            frame_new[0] = DATA_WIDTH'(HDR_RF_WR);
            frame_new[1] = DATA_WIDTH'(cmd_addr);
            frame_new[2] = cmd_wdata;
         end
         OP_RF_RD: begin
            frame_new[0] = DATA_WIDTH'(HDR_RF_RD);
            frame_new[1] = DATA_WIDTH'(cmd_addr);
         end
         OP_ALU_OP: begin
            frame_new[0] = DATA_WIDTH'(HDR_ALU_OP);
            frame_new[1] = cmd_a;
            frame_new[2] = cmd_b;
            frame_new[3] = DATA_WIDTH'(cmd_fun);
         end
         OP_ALU_NOP: begin
            frame_new[0] = DATA_WIDTH'(HDR_ALU_NOP);
            frame_new[1] = DATA_WIDTH'(cmd_fun);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      tx_valid    = 1'b0;
      tx_p_data   = '0;
      resp_valid  = 1'b0;
      timeout_err = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cmd_valid) state_nxt = S_OFFER;
         end
         S_OFFER: begin
            if (!tx_busy) begin
               tx_valid  = 1'b1;
               tx_p_data = frame_q[byte_idx];
               state_nxt = S_WAIT_ACC;
            end
         end
         S_WAIT_ACC: begin
            if (tx_busy) begin
               state_nxt = S_WAIT_DONE;
            end else begin
               tx_valid  = 1'b1;
               tx_p_data = frame_q[byte_idx];
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               if (!last_byte)             state_nxt = S_OFFER;
               else if (op_q == OP_RF_WR)  state_nxt = S_FINISH;
               else                        state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            // A byte arriving on the expiry cycle wins over the timeout.
            if (rx_valid) begin
               if (rx_final) state_nxt = S_FINISH;
            end else if (tmr_expired) begin
               timeout_err = 1'b1;
               state_nxt   = S_IDLE;
            end
         end
         S_FINISH: begin
            resp_valid = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= OP_RF_WR;
         byte_idx  <= '0;
         rx_cnt    <= '0;
         rx_lo     <= '0;
         resp_data <= '0;
         for (int i = 0; i < 4; i++) begin
            frame_q[i] <= '0;
         end
      end else begin
         if (handshake) begin
            op_q     <= op_in;
            byte_idx <= '0;
            rx_cnt   <= '0;
            for (int i = 0; i < 4; i++) begin
               frame_q[i] <= frame_new[i];
            end
         end
         if (byte_done && !last_byte) begin
            byte_idx <= byte_idx + 2'd1;
         end
         if (byte_done && last_byte && (op_q == OP_RF_WR)) begin
            resp_data <= '0;
         end
         // resp_data changes only on completion so a timeout leaves it intact.
         if (rx_take) begin
            rx_cnt <= rx_cnt + 2'd1;
            if (!rx_final) begin
               rx_lo <= rx_p_data;
            end else if (op_q == OP_RF_RD) begin
               resp_data <= {{DATA_WIDTH{1'b0}}, rx_p_data};
            end else begin
               resp_data <= {rx_p_data, rx_lo};
            end
         end
      end
   end

   cmd_frame_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmr_load),
      .dec     (tmr_dec),
      .expired (tmr_expired)
   );

endmodule

`default_nettype wire

// File: doc/cmd_frame_tx.md
CMD_FRAME_TX -- requirements
Module: cmd_frame_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the UART byte width.
REQ-002 SHALL have parameter RF_ADDR, default 4, meaning the register-file address width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096, meaning the response timeout in CLK cycles.
REQ-004 SHALL use one clock and an asynchronous active-low reset (already decided).
REQ-005 CLK  in  1  sole clock.
REQ-006 RST  in  1  async active-low reset.
REQ-007 CMD_VALID  in  1  command request.
REQ-008 CMD_READY  out  1  high only in IDLE.
REQ-009 CMD_OP  in  2  00 RF_WR, 01 RF_RD, 10 ALU_OP (with operands), 11 ALU_NOP.
REQ-010 CMD_ADDR  in  RF_ADDR  RF address.
REQ-011 CMD_WDATA  in  DATA_WIDTH  RF write data.
REQ-012 CMD_A, CMD_B  in  DATA_WIDTH each  ALU operands.
REQ-013 CMD_FUN  in  4  ALU function.
REQ-014 TX_P_DATA  out  DATA_WIDTH  byte to the UART transmitter.
REQ-015 TX_VALID  out  1  byte offer.
REQ-016 TX_BUSY  in  1  transmitter busy level.
REQ-017 RX_P_DATA  in  DATA_WIDTH  response byte.
REQ-018 RX_VALID  in  1  one-cycle response strobe.
REQ-019 RESP_DATA  out  2*DATA_WIDTH  assembled response.
REQ-020 RESP_VALID  out  1  one-cycle pulse.
REQ-021 TIMEOUT_ERR  out  1  one-cycle pulse.
REQ-022 FRAME_BUSY  out  1  high in every state other than IDLE.

Function
REQ-023 Frames SHALL be built as follows; all fields SHALL be captured on the CMD_VALID and CMD_READY handshake.
- RF_WR: AA, addr, data (3 bytes).
- RF_RD: BB, addr (2 bytes).
- ALU_OP: CC, A, B, fun (4 bytes).
- ALU_NOP: DD, fun (2 bytes).
- The addr and fun fields SHALL be zero-extended to DATA_WIDTH.
REQ-024 The FSM SHALL have the states IDLE, OFFER, WAIT_ACC, WAIT_DONE, RESP and FINISH.
REQ-025 IDLE SHALL go to OFFER on the handshake and SHALL clear the byte index and the response count.
REQ-026 OFFER SHALL drive TX_VALID=1 with the indexed byte only while TX_BUSY=0, then go to WAIT_ACC.
REQ-027 WAIT_ACC SHALL hold TX_VALID and TX_P_DATA stable until TX_BUSY=1, then drop TX_VALID and go to WAIT_DONE.
REQ-028 WAIT_DONE SHALL wait for TX_BUSY=0.
- If bytes remain, it SHALL increment the index and go to OFFER.
- Otherwise it SHALL go to RESP, or to FINISH for RF_WR, and SHALL load the timeout counter.
REQ-029 The expected response count SHALL be 1 byte for RF_RD and 2 bytes for ALU_OP and ALU_NOP.
REQ-030 ALU responses SHALL arrive LSB first.
REQ-031 An RF_RD response SHALL set RESP_DATA[15:8]=0.
REQ-032 In RESP, each RX_VALID SHALL store its byte, increment the count and reload the timeout counter.
REQ-033 When the final byte is stored, the block SHALL pulse RESP_VALID for 1 cycle, one cycle after that RX_VALID, and return to IDLE.
REQ-034 RF_WR SHALL pulse RESP_VALID with RESP_DATA=0 in FINISH, then return to IDLE.
REQ-035 If the timeout counter reaches 0 in RESP, the block SHALL pulse TIMEOUT_ERR and return to IDLE; RESP_DATA SHALL keep its last value.
REQ-036 The timeout counter SHALL satisfy:
- RX_VALID on the same cycle as expiry SHALL take priority over the timeout.
- The counter SHALL be only as wide as needed for TIMEOUT_CYC.
- The counter SHALL saturate at 0.
REQ-037 RX_VALID outside RESP SHALL be ignored.
REQ-038 CMD_VALID while CMD_READY=0 SHALL be ignored, and no request SHALL be queued.
REQ-039 RESP_VALID and TIMEOUT_ERR SHALL never be high together.

Reset
REQ-040 Asserting RST SHALL immediately force IDLE and set every output to 0 except CMD_READY, which SHALL be 1, including when reset lands mid-frame.
REQ-041 A partially sent frame SHALL NOT be resumed after reset.

Structure
REQ-042 A shared package SHALL hold:
- the opcode encodings;
- the header constants AA, BB, CC and DD;
- the frame-length and response-length tables;
- the FSM state type.
REQ-043 One sub-module, cmd_frame_timer, SHALL implement the loadable, saturating timeout counter.

Verification
REQ-044 RF_WR, addr 5, data 3C, with TX_BUSY modelled 10 cycles high per byte -> bytes AA,05,3C in order -> RESP_VALID with 0000 -> no timeout.
REQ-045 RF_RD, addr 2, with response 7E -> bytes BB,02 -> RESP_DATA=007E one cycle after RX_VALID.
REQ-046 ALU_OP, A=0A, B=03, fun 0, with responses 0D then 00 -> bytes CC,0A,03,00 -> RESP_DATA=000D.
REQ-047 ALU_NOP, fun 2, with no response -> bytes DD,02 -> TIMEOUT_ERR exactly TIMEOUT_CYC cycles after TX_BUSY falls -> CMD_READY=1 on the next cycle.
REQ-048 RST asserted while the second byte of an ALU_OP frame is in WAIT_ACC -> TX_VALID=0 and CMD_READY=1 immediately -> a new RF_RD after release sends BB first.
REQ-049 RX_VALID pulses while idle, plus CMD_VALID held during a frame -> no RESP_VALID and no extra frames.
